// File: rtl/coalescing_wait_buffer.sv
// coalescing_wait_buffer: byte-granular store buffer that coalesces into the youngest entry,
// drains in FIFO order and forwards bytes to loads (newest store wins).
module coalescing_wait_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS = 32,
  parameter int DEPTH = 8,
  parameter int TAG_WIDTH = 14,
  localparam int BE = DATA_WIDTH / 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [ADDR_BITS-1:0]  push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [BE-1:0]         push_be,
  input  logic [TAG_WIDTH-1:0]  push_tag,
  output logic                  push_merged,
  output logic                  drain_valid,
  input  logic                  drain_ready,
  output logic [ADDR_BITS-1:0]  drain_addr,
  output logic [DATA_WIDTH-1:0] drain_data,
  output logic [BE-1:0]         drain_be,
  output logic [TAG_WIDTH-1:0]  drain_tag,
  input  logic [ADDR_BITS-1:0]  lookup_addr,
  input  logic [BE-1:0]         lookup_be,
  output logic                  lookup_hit,
  output logic                  lookup_full,
  output logic [DATA_WIDTH-1:0] lookup_data,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_BITS-1:0] MASK = ~ADDR_BITS'(BE - 1);
  logic [DEPTH-1:0] vld;
  logic [ADDR_BITS-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [BE-1:0] be_q [DEPTH];
  logic [TAG_WIDTH-1:0] tag_q [DEPTH];
  logic [PW-1:0] head, tail, last, wi;
  logic [ADDR_BITS-1:0] waddr;
  logic [BE-1:0] found;
  logic merge, accept, alloc, drain;
  assign waddr = push_addr & MASK;
  assign last = tail - PW'(1);
  // count >= 2 guarantees tail-1 is not the head, so drain outputs never change under a merge
  assign merge = count >= CW'(2) && addr_q[last] == waddr;
  assign push_ready = !flush && (merge || count < CW'(DEPTH));
  assign accept = push_valid && push_ready;
  assign alloc = accept && !merge;
  assign push_merged = accept && merge;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign drain_valid = !empty;
  assign drain = drain_valid && drain_ready && !flush;
  assign drain_addr = drain_valid ? addr_q[head] : '0;
  assign drain_data = drain_valid ? data_q[head] : '0;
  assign drain_be = drain_valid ? be_q[head] : '0;
  assign drain_tag = drain_valid ? tag_q[head] : '0;
  assign wi = merge ? last : tail;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      vld <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      vld <= '0;
    end else begin
      if (drain) begin
        vld[head] <= 1'b0;
        head <= head + PW'(1);
      end
      if (alloc) begin
        vld[tail] <= 1'b1;
        tail <= tail + PW'(1);
      end
      count <= count + CW'(alloc) - CW'(drain);
    end
  always_ff @(posedge clk)
    if (accept) begin
      for (int b = 0; b < BE; b++)
        if (!merge || push_be[b]) data_q[wi][8*b +: 8] <= push_data[8*b +: 8];
      be_q[wi] <= merge ? (be_q[last] | push_be) : push_be;
      addr_q[wi] <= waddr;
      tag_q[wi] <= push_tag;
    end
  // walk oldest to newest so the youngest matching byte overwrites older ones
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    found = '0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (vld[idx] && addr_q[idx] == (lookup_addr & MASK))
        for (int b = 0; b < BE; b++)
          if (be_q[idx][b]) begin
            found[b] = 1'b1;
            lookup_data[8*b +: 8] = data_q[idx][8*b +: 8];
          end
    end
  end
  assign lookup_hit = |(lookup_be & found);
  assign lookup_full = lookup_be != '0 && (lookup_be & found) == lookup_be;
endmodule

// File: tb/tb_coalescing_wait_buffer.sv
// tb_coalescing_wait_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_coalescing_wait_buffer;
  localparam int D = 8;
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] be; logic [13:0] t;} ent_t;
  logic clk = 0, rst_n = 0, flush = 0, push_valid = 0, drain_ready = 0;
  logic push_ready, push_merged, drain_valid, lookup_hit, lookup_full, empty, full;
  logic [31:0] push_addr = 0, push_data = 0, lookup_addr = 0, drain_addr, drain_data, lookup_data;
  logic [3:0] push_be = 0, lookup_be = 0, drain_be, count;
  logic [13:0] push_tag = 0, drain_tag;
  int total = 0, bad = 0;
  ent_t q[$];
  always #5 clk = ~clk;
  coalescing_wait_buffer dut (.clk(clk), .rst_n(rst_n), .flush(flush), .push_valid(push_valid),
    .push_ready(push_ready), .push_addr(push_addr), .push_data(push_data), .push_be(push_be),
    .push_tag(push_tag), .push_merged(push_merged), .drain_valid(drain_valid), .drain_ready(drain_ready),
    .drain_addr(drain_addr), .drain_data(drain_data), .drain_be(drain_be), .drain_tag(drain_tag),
    .lookup_addr(lookup_addr), .lookup_be(lookup_be), .lookup_hit(lookup_hit), .lookup_full(lookup_full),
    .lookup_data(lookup_data), .count(count), .empty(empty), .full(full));
  function automatic logic [31:0] wa(logic [31:0] a);
    return a & ~32'h3;
  endfunction
  function automatic bit m_merge(logic [31:0] a);
    return q.size() >= 2 && q[q.size()-1].a == wa(a);
  endfunction
  function automatic void m_lookup(input logic [31:0] a, input logic [3:0] be,
                                   output logic hit, output logic fl, output logic [31:0] d);
    logic [3:0] f;
    f = 0;
    d = 0;
    for (int b = 0; b < 4; b++)
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].a == wa(a) && q[i].be[b]) begin
          f[b] = 1;
          d[8*b +: 8] = q[i].d[8*b +: 8];
          break;
        end
    hit = |(f & be);
    fl = be != 0 && (f & be) == be;
  endfunction
  task automatic tick();
    bit fl, mg, acc, dr;
    ent_t e, y;
    fl = flush;
    mg = m_merge(push_addr);
    acc = push_valid && !fl && (mg || q.size() < D);
    dr = drain_ready && !fl && q.size() > 0;
    e = '{wa(push_addr), push_data, push_be, push_tag};
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (acc && mg) begin
        y = q[q.size()-1];
        for (int b = 0; b < 4; b++) if (e.be[b]) y.d[8*b +: 8] = e.d[8*b +: 8];
        y.be |= e.be;
        y.t = e.t;
        q[q.size()-1] = y;
      end
      if (dr) void'(q.pop_front());
      if (acc && !mg) q.push_back(e);
    end
  endtask
  task automatic drive(input bit pv, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input bit dr);
    push_valid = pv;
    push_addr = a;
    push_data = d;
    push_be = be;
    push_tag = 14'($urandom);
    drain_ready = dr;
  endtask
  task automatic do_flush();
    drive(0, 0, 0, 0, 0);
    flush = 1;
    tick();
    flush = 0;
  endtask
  task automatic test_reset();
    #1;
    total++; if (count !== 0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1 || full !== 0) begin bad++; $display("FAIL reset_flags got=%b%b exp=10", empty, full); end
    total++; if (drain_valid !== 0 || push_ready !== 1 || push_merged !== 0) begin bad++;
      $display("FAIL reset_hs got=%b%b%b exp=010", drain_valid, push_ready, push_merged); end
    total++; if (lookup_hit !== 0 || lookup_full !== 0 || drain_addr !== 0 || lookup_data !== 0) begin bad++;
      $display("FAIL reset_data got=%b%b %h %h exp=00 0 0", lookup_hit, lookup_full, drain_addr, lookup_data); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_basic();
    drive(1, 32'h100, 32'h11223344, 4'hF, 0);
    #1;
    total++; if (push_ready !== 1 || push_merged !== 0) begin bad++;
      $display("FAIL basic_push got=%b%b exp=10", push_ready, push_merged); end
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    total++; if (count !== 1 || drain_valid !== 1) begin bad++;
      $display("FAIL basic_count got=%0d/%b exp=1/1", count, drain_valid); end
    total++; if (drain_addr !== 32'h100 || drain_be !== 4'hF || drain_data !== 32'h11223344) begin bad++;
      $display("FAIL basic_drain got=%h %h %h exp=100 f 11223344", drain_addr, drain_be, drain_data); end
  endtask
  task automatic test_merge();
    drive(1, 32'h200, 32'h0000AAAA, 4'h3, 0);
    tick();
    drive(1, 32'h201, 32'hBBBB0000, 4'hC, 0);
    #1;
    total++; if (push_merged !== 1 || push_ready !== 1) begin bad++;
      $display("FAIL merge_flag got=%b%b exp=11", push_merged, push_ready); end
    tick();
    drive(0, 0, 0, 0, 0);
    lookup_addr = 32'h200;
    lookup_be = 4'hF;
    #1;
    total++; if (count !== 2) begin bad++; $display("FAIL merge_count got=%0d exp=2", count); end
    total++; if (lookup_data !== 32'hBBBBAAAA || lookup_full !== 1) begin bad++;
      $display("FAIL merge_data got=%h/%b exp=bbbbaaaa/1", lookup_data, lookup_full); end
    drain_ready = 1;
    tick();
    drain_ready = 0;
    #1;
    total++; if (drain_be !== 4'hF || drain_data !== 32'hBBBBAAAA || drain_addr !== 32'h200) begin bad++;
      $display("FAIL merge_head got=%h %h %h exp=200 f bbbbaaaa", drain_addr, drain_be, drain_data); end
    drive(1, 32'h200, 32'h5, 4'h1, 0);
    #1;
    total++; if (push_merged !== 0) begin bad++; $display("FAIL merge_head_only got=%b exp=0", push_merged); end
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    total++; if (count !== 2) begin bad++; $display("FAIL merge_newent got=%0d exp=2", count); end
    do_flush();
  endtask
  task automatic test_forward();
    drive(1, 32'h300, 32'h11, 4'h1, 0);
    tick();
    drive(1, 32'h400, 32'hDEADBEEF, 4'hF, 0);
    tick();
    drive(1, 32'h300, 32'h22, 4'h1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    lookup_addr = 32'h302;
    lookup_be = 4'h3;
    #1;
    total++; if (lookup_hit !== 1 || lookup_full !== 0 || lookup_data[7:0] !== 8'h22) begin bad++;
      $display("FAIL fwd_newest got=%b%b %h exp=10 byte0=22", lookup_hit, lookup_full, lookup_data); end
    lookup_be = 4'h1;
    #1;
    total++; if (lookup_full !== 1) begin bad++; $display("FAIL fwd_full got=%b exp=1", lookup_full); end
    lookup_be = 4'h0;
    #1;
    total++; if (lookup_hit !== 0 || lookup_full !== 0) begin bad++;
      $display("FAIL fwd_nobe got=%b%b exp=00", lookup_hit, lookup_full); end
    do_flush();
  endtask
  task automatic test_fill_wrap();
    for (int i = 0; i < 3; i++) begin drive(1, 32'h40 * i, i, 4'hF, 0); tick(); end
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 1); tick(); end
    for (int i = 0; i < D; i++) begin drive(1, 32'h1000 + 16 * i, i, 4'hF, 0); tick(); end
    drive(1, 32'h5000, 0, 4'hF, 1);
    #1;
    total++; if (full !== 1 || push_ready !== 0) begin bad++;
      $display("FAIL fill_full got=%b%b exp=10", full, push_ready); end
    push_addr = 32'h1070;
    #1;
    total++; if (push_ready !== 1 || push_merged !== 1) begin bad++;
      $display("FAIL fill_merge got=%b%b exp=11", push_ready, push_merged); end
    push_addr = 32'h5000;
    for (int i = 0; i < D; i++) begin
      #1;
      total++; if (drain_addr !== 32'h1000 + 16 * i) begin bad++;
        $display("FAIL fill_order got=%h exp=%h", drain_addr, 32'h1000 + 16 * i); end
      tick();
      push_valid = 0;
    end
    total++; if (empty !== 1) begin bad++; $display("FAIL fill_empty got=%b exp=1", empty); end
    drive(1, 32'h7000, 1, 4'hF, 0);
    tick();
    drive(1, 32'h7010, 2, 4'hF, 0);
    tick();
    drive(0, 0, 0, 0, 1);
    #1;
    total++; if (drain_addr !== 32'h7000) begin bad++; $display("FAIL wrap_first got=%h exp=7000", drain_addr); end
    tick();
    total++; if (drain_addr !== 32'h7010) begin bad++; $display("FAIL wrap_second got=%h exp=7010", drain_addr); end
    tick();
    drain_ready = 0;
  endtask
  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin drive(1, 32'h800 + 4 * i, i, 4'hF, 0); tick(); end
    drive(1, 32'h900, 0, 4'hF, 1);
    flush = 1;
    #1;
    total++; if (push_ready !== 0 || count !== 3) begin bad++;
      $display("FAIL flush_ready got=%b/%0d exp=0/3", push_ready, count); end
    tick();
    flush = 0;
    drive(0, 0, 0, 0, 0);
    #1;
    total++; if (count !== 0 || empty !== 1 || drain_valid !== 0) begin bad++;
      $display("FAIL flush_clear got=%0d%b%b exp=010", count, empty, drain_valid); end
  endtask
  task automatic test_async_reset();
    drive(1, 32'hA00, 32'h12345678, 4'hF, 0);
    tick();
    drive(1, 32'hB00, 1, 4'hF, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    lookup_addr = 32'hA00;
    lookup_be = 4'hF;
    #1;
    rst_n = 0;
    #1;
    q.delete();
    total++; if (count !== 0 || drain_valid !== 0 || lookup_hit !== 0) begin bad++;
      $display("FAIL async_reset got=%0d%b%b exp=000", count, drain_valid, lookup_hit); end
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_random();
    logic [31:0] pool [4] = '{32'h100, 32'h104, 32'h200, 32'h300};
    logic eh, ef, er;
    logic [31:0] ed;
    ent_t h;
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 9) < 7, pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)),
            $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 1) == 1);
      flush = $urandom_range(0, 39) == 0;
      lookup_addr = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      lookup_be = 4'($urandom);
      #1;
      er = !flush && (m_merge(push_addr) || q.size() < D);
      h = q.size() > 0 ? q[0] : '0;
      m_lookup(lookup_addr, lookup_be, eh, ef, ed);
      total++; if (push_ready !== er || push_merged !== (push_valid && er && m_merge(push_addr))) begin bad++;
        $display("FAIL rnd_push got=%b%b exp=%b%b", push_ready, push_merged, er, push_valid && er && m_merge(push_addr)); end
      total++; if (count !== 4'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == D)) begin bad++;
        $display("FAIL rnd_count got=%0d%b%b exp=%0d", count, empty, full, q.size()); end
      total++; if (drain_valid !== (q.size() > 0) || {drain_addr, drain_data, drain_be, drain_tag} !== h) begin bad++;
        $display("FAIL rnd_drain got=%h %h %h %h exp=%h", drain_addr, drain_data, drain_be, drain_tag, h); end
      total++; if (lookup_hit !== eh || lookup_full !== ef || lookup_data !== ed) begin bad++;
        $display("FAIL rnd_lookup got=%b%b %h exp=%b%b %h", lookup_hit, lookup_full, lookup_data, eh, ef, ed); end
      tick();
    end
    flush = 0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_merge();
    test_forward();
    test_fill_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
